// File: rtl/sp_capture_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sp_capture_pkg
// Description : Shared state encoding and mode constants for the spectrum
//               snapshot capture controller.
// Revision    : 1.0 - initial release
// ============================================================================
package sp_capture_pkg;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_WAIT_EMPTY = 2'd1,
        ST_FILL       = 2'd2,
        ST_READY      = 2'd3
    } sp_cap_state_t;

    localparam logic SP_MODE_ONESHOT = 1'b0;
    localparam logic SP_MODE_CONT    = 1'b1;

endpackage
`default_nettype wire

// File: rtl/sp_decim_counter.sv
`default_nettype none
// ============================================================================
// Module      : sp_decim_counter
// Description : 8-bit phase counter; fire marks every (decim+1)-th tick.
// Revision    : 1.0 - initial release
// ============================================================================
module sp_decim_counter (
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic       tick,
    input  logic [7:0] decim,
    output logic       fire
);

    logic [7:0] r_phase;

    // >= keeps the counter from running past a decim that shrank mid-burst
    assign fire = tick & (r_phase >= decim);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            r_phase <= 8'd0;
        end else if (tick) begin
            r_phase <= fire ? 8'd0 : r_phase + 8'd1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/sp_capture_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : sp_capture_ctrl
// Description : Gates one selected sample channel into the SP_fifo in bursts
//               of exactly DEPTH samples, one-shot or continuous.
//               Optional decimator enabled by defining SP_CAPTURE_DECIM_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module sp_capture_ctrl
    import sp_capture_pkg::*;
#(
    parameter  int DEPTH = 16384,
    parameter  int NCH   = 2,
    parameter  int CW    = $clog2(DEPTH + 1),
    localparam int CHW   = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           mode,
    input  logic           arm,
    input  logic [CHW-1:0] ch_sel,
    input  logic [NCH-1:0] sample_valid,
    input  logic           sp_fifo_wrempty,
    input  logic           sp_fifo_wrfull,
`ifdef SP_CAPTURE_DECIM_EN
    input  logic [7:0]     decim,
`endif
    output logic           write,
    output logic [CHW-1:0] wr_ch,
    output logic           have_sp_data,
    output logic           busy,
    output logic [CW-1:0]  count,
    output logic           overrun
);

    localparam logic [CW-1:0] c_depth = CW'(DEPTH);
    localparam logic [CW-1:0] c_last  = CW'(DEPTH - 1);

    sp_cap_state_t  r_state;
    sp_cap_state_t  w_state_nxt;
    logic [CW-1:0]  r_count;
    logic [CHW-1:0] r_wr_ch;
    logic           r_overrun;

    logic w_sel_valid;
    logic w_room;
    logic w_start;
    logic w_tick;
    logic w_fire;
    logic w_write;
    logic w_overrun_set;

    always_comb begin
        w_sel_valid = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            if (r_wr_ch == CHW'(i)) begin
                w_sel_valid = sample_valid[i];
            end
        end
    end

    assign w_room        = (r_count < c_depth);
    assign w_start       = (r_state == ST_WAIT_EMPTY) & sp_fifo_wrempty;
    assign w_tick        = (r_state == ST_FILL) & w_sel_valid & w_room
                           & ~sp_fifo_wrfull & ~reset;
    assign w_write       = w_tick & w_fire;
    // a full FIFO with the burst unfinished means samples were lost
    assign w_overrun_set = (r_state == ST_FILL) & sp_fifo_wrfull & w_room;

`ifdef SP_CAPTURE_DECIM_EN
    sp_decim_counter u_decim (
        .clk   (clk),
        .reset (reset),
        .clear (w_start),
        .tick  (w_tick),
        .decim (decim),
        .fire  (w_fire)
    );
`else
    assign w_fire = 1'b1;
`endif

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if ((mode == SP_MODE_CONT) || arm) w_state_nxt = ST_WAIT_EMPTY;
            end
            ST_WAIT_EMPTY: begin
                if (sp_fifo_wrempty) w_state_nxt = ST_FILL;
            end
            ST_FILL: begin
                if (sp_fifo_wrfull || !w_room || (w_write && (r_count == c_last)))
                    w_state_nxt = ST_READY;
            end
            ST_READY: begin
                if (arm || ((mode == SP_MODE_CONT) && sp_fifo_wrempty))
                    w_state_nxt = ST_WAIT_EMPTY;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_count   <= '0;
            r_wr_ch   <= '0;
            r_overrun <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_start) begin
                r_count <= '0;
                r_wr_ch <= ch_sel;
            end else if (w_write) begin
                r_count <= r_count + CW'(1);
            end
            if (w_overrun_set) begin
                r_overrun <= 1'b1;
            end else if (arm) begin
                r_overrun <= 1'b0;
            end
        end
    end

    assign write        = w_write;
    assign wr_ch        = r_wr_ch;
    assign have_sp_data = (r_state == ST_READY);
    assign busy         = (r_state == ST_WAIT_EMPTY) | (r_state == ST_FILL);
    assign count        = r_count;
    assign overrun      = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_sp_capture_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_sp_capture_ctrl
// Description : Directed self-checking bench for sp_capture_ctrl with a
//               write scoreboard (DEPTH=16, NCH=2).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sp_capture_ctrl;

    localparam int DEPTH = 16;
    localparam int NCH   = 2;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          reset;
    logic          mode;
    logic          arm;
    logic [0:0]    ch_sel;
    logic [1:0]    sample_valid;
    logic          wrempty;
    logic          wrfull;
`ifdef SP_CAPTURE_DECIM_EN
    logic [7:0]    decim;
`endif
    logic          write;
    logic [0:0]    wr_ch;
    logic          have_sp_data;
    logic          busy;
    logic [CW-1:0] count;
    logic          overrun;

    always #5 clk = ~clk;

    sp_capture_ctrl #(.DEPTH(DEPTH), .NCH(NCH)) dut (
        .clk             (clk),
        .reset           (reset),
        .mode            (mode),
        .arm             (arm),
        .ch_sel          (ch_sel),
        .sample_valid    (sample_valid),
        .sp_fifo_wrempty (wrempty),
        .sp_fifo_wrfull  (wrfull),
`ifdef SP_CAPTURE_DECIM_EN
        .decim           (decim),
`endif
        .write           (write),
        .wr_ch           (wr_ch),
        .have_sp_data    (have_sp_data),
        .busy            (busy),
        .count           (count),
        .overrun         (overrun)
    );

    typedef struct packed {
        logic [CW-1:0] cnt;
        logic          ch;
    } exp_t;

    exp_t sb_q[$];
    exp_t m_e;
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_burst(input int n, input logic ch);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.cnt = CW'(i);
            e.ch  = ch;
            sb_q.push_back(e);
        end
    endtask

    task automatic pulse_arm();
        arm = 1'b1;
        step();
        arm = 1'b0;
    endtask

    task automatic wait_ready(input string tag, input int budget);
        int b = 0;
        while (have_sp_data !== 1'b1 && b < budget) begin
            step();
            b++;
        end
        chk($sformatf("%s_ready_timeout", tag), 32'(have_sp_data === 1'b1), 32'd1);
    endtask

    task automatic wait_count(input string tag, input int value, input int budget);
        int b = 0;
        while (count !== CW'(value) && b < budget) begin
            step();
            b++;
        end
        chk($sformatf("%s_count_timeout", tag), 32'(count), 32'(value));
    endtask

    // Scoreboard: every observed write must match the next expected entry
    always @(negedge clk) begin
        if (write === 1'b1) begin
            chk("write_in_reset", 32'(reset), 32'd0);
            chk("sb_has_entry", 32'(sb_q.size() > 0), 32'd1);
            if (sb_q.size() > 0) begin
                m_e = sb_q.pop_front();
                chk("wr_count", 32'(count), 32'(m_e.cnt));
                chk("wr_channel", 32'(wr_ch), 32'(m_e.ch));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int mcnt;
        int n;
        reset        = 1'b1;
        mode         = 1'b0;
        arm          = 1'b0;
        ch_sel       = 1'b0;
        sample_valid = 2'b11;
        wrempty      = 1'b1;
        wrfull       = 1'b0;
`ifdef SP_CAPTURE_DECIM_EN
        decim        = 8'd0;
`endif
        repeat (3) step();
        chk("rst_write",   32'(write),        32'd0);
        chk("rst_have",    32'(have_sp_data), 32'd0);
        chk("rst_busy",    32'(busy),         32'd0);
        chk("rst_count",   32'(count),        32'd0);
        chk("rst_wr_ch",   32'(wr_ch),        32'd0);
        chk("rst_overrun", 32'(overrun),      32'd0);
        reset = 1'b0;
        step();
        step();
        chk("idle_busy", 32'(busy), 32'd0);

        // one-shot burst
        push_burst(16, 1'b0);
        arm = 1'b1;
        #1;
        chk("arm_cycle_busy", 32'(busy), 32'd0);
        step();
        arm = 1'b0;
        chk("arm_latency_busy", 32'(busy), 32'd1);
        chk("wait_empty_write", 32'(write), 32'd0);
        step();
        chk("first_fill_write", 32'(write), 32'd1);
        chk("first_fill_count", 32'(count), 32'd0);
        wait_ready("oneshot", 40);
        chk("oneshot_count",   32'(count),       32'd16);
        chk("oneshot_busy",    32'(busy),        32'd0);
        chk("oneshot_overrun", 32'(overrun),     32'd0);
        chk("oneshot_sb",      32'(sb_q.size()), 32'd0);
        repeat (10) step();
        chk("oneshot_hold", 32'(have_sp_data), 32'd1);

        // continuous bursts, each released by the FIFO draining
        wrempty = 1'b0;
        mode    = 1'b1;
        repeat (3) step();
        chk("cont_wait_drain", 32'(have_sp_data), 32'd1);
        for (int b = 0; b < 3; b++) begin
            push_burst(16, 1'b0);
            wrempty = 1'b1;
            step();
            chk($sformatf("cont%0d_latency", b), 32'(busy), 32'd1);
            step();
            wrempty = 1'b0;
            wait_ready($sformatf("cont%0d", b), 40);
            chk($sformatf("cont%0d_count", b), 32'(count), 32'd16);
        end
        mode    = 1'b0;
        wrempty = 1'b1;
        repeat (4) step();
        chk("mode_drop_hold", 32'(have_sp_data), 32'd1);

        // channel latch: ch_sel changes mid-burst must not matter
        ch_sel = 1'b1;
        push_burst(16, 1'b1);
        pulse_arm();
        step();
        mcnt = 0;
        for (int k = 0; k < 100 && mcnt < 16; k++) begin
            sample_valid = (k % 3 == 0) ? 2'b01 : ((k % 3 == 1) ? 2'b10 : 2'b11);
            if (k == 4) ch_sel = 1'b0;
            #1;
            chk("ch1_write", 32'(write), 32'(sample_valid[1]));
            if (sample_valid[1]) mcnt++;
            step();
        end
        chk("ch_have",  32'(have_sp_data), 32'd1);
        chk("ch_wr_ch", 32'(wr_ch),        32'd1);
        chk("ch_count", 32'(count),        32'd16);
        sample_valid = 2'b11;
        ch_sel       = 1'b0;

        // FIFO full at count 10
        push_burst(10, 1'b0);
        pulse_arm();
        wait_count("ovr10", 10, 40);
        wrfull = 1'b1;
        #1;
        chk("full_no_write", 32'(write), 32'd0);
        step();
        chk("ovr10_overrun", 32'(overrun),      32'd1);
        chk("ovr10_have",    32'(have_sp_data), 32'd1);
        chk("ovr10_count",   32'(count),        32'd10);
        wrfull = 1'b0;

        // arm clears overrun; then full coincides with the final write
        push_burst(15, 1'b0);
        pulse_arm();
        chk("arm_clears_overrun", 32'(overrun), 32'd0);
        wait_count("ovr15", 15, 40);
        wrfull = 1'b1;
        #1;
        chk("final_full_no_write", 32'(write), 32'd0);
        step();
        chk("ovr15_overrun", 32'(overrun),      32'd1);
        chk("ovr15_count",   32'(count),        32'd15);
        chk("ovr15_have",    32'(have_sp_data), 32'd1);
        wrfull = 1'b0;
        push_burst(16, 1'b0);
        pulse_arm();
        chk("rearm_overrun", 32'(overrun), 32'd0);
        wait_ready("rearm", 40);
        chk("rearm_count", 32'(count), 32'd16);

        // reset mid-burst
        push_burst(7, 1'b0);
        pulse_arm();
        wait_count("rst7", 7, 40);
        reset = 1'b1;
        #1;
        chk("reset_cycle_write", 32'(write), 32'd0);
        step();
        chk("rst7_have",    32'(have_sp_data), 32'd0);
        chk("rst7_busy",    32'(busy),         32'd0);
        chk("rst7_count",   32'(count),        32'd0);
        chk("rst7_wr_ch",   32'(wr_ch),        32'd0);
        chk("rst7_overrun", 32'(overrun),      32'd0);
        reset = 1'b0;
        step();
        chk("rst7_idle_write", 32'(write), 32'd0);
        push_burst(16, 1'b0);
        pulse_arm();
        wait_ready("post_rst", 40);
        chk("post_rst_count", 32'(count), 32'd16);

`ifdef SP_CAPTURE_DECIM_EN
        // decimate by 4: 16 writes take 64 FILL cycles
        decim = 8'd3;
        push_burst(16, 1'b0);
        pulse_arm();
        step();
        n = 0;
        while (have_sp_data !== 1'b1 && n < 200) begin
            step();
            n++;
        end
        chk("decim_cycles", 32'(n), 32'd64);
        chk("decim_count", 32'(count), 32'd16);
        decim = 8'd0;
`else
        n = 0;
`endif

        repeat (3) step();
        chk("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
